// File: rtl/dmem_responder_if.sv
// Request/response bundle between the core's memory stage and the
// data-memory responder.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic        req_byte;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_byte, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_byte, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM without byte enables, so byte
// stores are done as read-modify-write. One request in flight.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic            clk,
   input  logic            reset,
   dmem_responder_if.slave bus,
   output logic            busy
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic          we_q, we_d;
   logic          byte_q, byte_d;
   logic          err_q, err_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [1:0]    lane_q, lane_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   ram_q;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          accept;
   logic          misal;
   logic          ram_we;
   logic [4:0]    shamt;
   logic [31:0]   wr_word;
   logic [7:0]    lane_byte;
   logic          unused_addr;

   assign unused_addr = ^bus.req_addr[31:AW+2];

   assign bus.req_ready = (state_q == IDLE) && !reset;
   assign accept = bus.req_valid && bus.req_ready;
   assign misal  = !bus.req_byte && (bus.req_addr[1:0] != 2'b00);
   assign ram_we = (state_q == WRITE) && !reset;
   assign shamt  = {lane_q, 3'b000};

   // Byte store merges the new byte into the word read in READ
   assign wr_word = byte_q
      ? ((ram_q & ~(32'hFF << shamt)) | ({24'b0, wdata_q[7:0]} << shamt))
      : wdata_q;

   // Pick the addressed lane of the read word for byte loads
   always_comb begin
      lane_byte = ram_q[7:0];
      unique case (lane_q)
         2'd0: lane_byte = ram_q[7:0];
         2'd1: lane_byte = ram_q[15:8];
         2'd2: lane_byte = ram_q[23:16];
         2'd3: lane_byte = ram_q[31:24];
      endcase
   end

   // State register and request latch; reset aborts any request
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         byte_q  <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         lane_q  <= 2'b00;
         wdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         byte_q  <= byte_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         lane_q  <= lane_d;
         wdata_q <= wdata_d;
      end
   end

   // Single-port RAM: read in READ, write in WRITE; contents never cleared
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[idx_q] <= wr_word;
      end
      if (state_q == READ) begin
         ram_q <= mem[idx_q];
      end
   end

   // Next-state and request capture on accept
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      byte_d  = byte_q;
      err_d   = err_q;
      idx_d   = idx_q;
      lane_d  = lane_q;
      wdata_d = wdata_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               we_d    = bus.req_we;
               byte_d  = bus.req_byte;
               err_d   = misal;
               idx_d   = bus.req_addr[AW+1:2];
               lane_d  = bus.req_addr[1:0];
               wdata_d = bus.req_wdata;
               if (misal) begin
                  state_d = RESP;
               end else if (bus.req_we && !bus.req_byte) begin
                  state_d = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ:  state_d = we_q ? WRITE : RESP;
         WRITE: state_d = RESP;
         RESP:  state_d = IDLE;
      endcase
   end

   // Response outputs, valid only in RESP and never while in reset
   always_comb begin
      bus.rsp_valid = 1'b0;
      bus.rsp_rdata = 32'h0;
      bus.rsp_err   = 1'b0;
      busy          = (state_q != IDLE) && !reset;
      if ((state_q == RESP) && !reset) begin
         bus.rsp_valid = 1'b1;
         bus.rsp_err   = err_q;
         if (!we_q && !err_q) begin
            bus.rsp_rdata = byte_q ? {24'b0, lane_byte} : ram_q;
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a flat-array memory
// model with per-request latency, data and error expectations.
module tb_dmem_responder;
   localparam int DEPTH = 256;

   logic clk = 1'b0;
   logic reset;
   logic busy;

   dmem_responder_if bus ();

   dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   logic [31:0] ref_mem [DEPTH];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
   endtask

   function automatic int widx(input logic [31:0] addr);
      return int'((addr / 4) % DEPTH);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] addr,
                                            input logic byt);
      logic [31:0] w;
      w = ref_mem[widx(addr)];
      if (byt) return (w >> (8 * (addr % 4))) & 32'hFF;
      return w;
   endfunction

   task automatic ref_store(input logic [31:0] addr, input logic byt,
                            input logic [31:0] wd);
      int k;
      logic [31:0] m;
      k = widx(addr);
      if (byt) begin
         m = 32'hFF << (8 * (addr % 4));
         ref_mem[k] = (ref_mem[k] & ~m) | ((wd & 32'hFF) << (8 * (addr % 4)));
      end else begin
         ref_mem[k] = wd;
      end
   endtask

   // One request, called and returning at 1 ns after a rising edge
   task automatic xact(input string tag, input logic we, input logic byt,
                       input logic [31:0] addr, input logic [31:0] wd);
      int n;
      int lat_exp;
      logic err_exp;
      logic [31:0] rd_exp;
      err_exp = !byt && (addr % 4 != 0);
      lat_exp = err_exp ? 1 : (we && byt) ? 3 : 2;
      rd_exp  = (err_exp || we) ? 32'h0 : ref_load(addr, byt);
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_byte  = byt;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'($urandom);
      bus.req_byte  = 1'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      n = 1;
      while (!bus.rsp_valid && n < 8) begin
         chk({tag, "_idle_rdata"}, bus.rsp_rdata, 32'h0);
         @(posedge clk); #1; n++;
      end
      chk({tag, "_lat"}, n, lat_exp);
      chk({tag, "_rdata"}, bus.rsp_rdata, rd_exp);
      chk({tag, "_err"}, {31'b0, bus.rsp_err}, {31'b0, err_exp});
      if (we && !err_exp) ref_store(addr, byt, wd);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, {31'b0, bus.rsp_valid}, 32'h0);
   endtask

   task automatic b2b();
      logic [31:0] q[$];
      int issued;
      int pulses;
      logic [31:0] a;
      issued = 0;
      pulses = 0;
      bus.req_we   = 1'b0;
      bus.req_byte = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (bus.rsp_valid) begin
            pulses++;
            if (q.size() > 0) chk("b2b_data", bus.rsp_rdata, q.pop_front());
         end
         if (busy) chk("b2b_ready", {31'b0, bus.req_ready}, 32'h0);
         if (bus.req_ready && issued < 3) begin
            a = 32'h20 + 32'(issued * 4);
            bus.req_addr  = a;
            bus.req_valid = 1'b1;
            q.push_back(ref_load(a, 1'b0));
            issued++;
         end else if (bus.req_ready) begin
            bus.req_valid = 1'b0;
         end
         @(posedge clk); #1;
      end
      bus.req_valid = 1'b0;
      chk("b2b_pulses", pulses, 3);
   endtask

   task automatic abort_test();
      int pulses;
      logic [7:0] ob;
      ob = 8'(ref_load(32'h15, 1'b1));
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_byte  = 1'b1;
      bus.req_addr  = 32'h15;
      bus.req_wdata = {24'h0, ~ob};
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      chk("abort_busy", {31'b0, busy}, 32'h1);
      reset = 1'b1;
      #1;
      chk("abort_rst_busy", {31'b0, busy}, 32'h0);
      chk("abort_rst_ready", {31'b0, bus.req_ready}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         if (bus.rsp_valid) pulses++;
         @(posedge clk); #1;
      end
      chk("abort_no_rsp", pulses, 0);
      xact("abort_word", 1'b0, 1'b0, 32'h14, 32'h0);
   endtask

   initial begin
      logic we;
      logic byt;
      logic [31:0] a;
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_byte  = 1'b0;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'b0, bus.req_ready}, 32'h0);
      chk("rst_valid", {31'b0, bus.rsp_valid}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_err", {31'b0, bus.rsp_err}, 32'h0);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", {31'b0, bus.req_ready}, 32'h1);
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++)
         xact("init", 1'b1, 1'b0, 32'(i * 4), $urandom);

      xact("t1_st", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
      xact("t1_ld", 1'b0, 1'b0, 32'h10, 32'h0);
      xact("t2_st", 1'b1, 1'b0, 32'h10, 32'h11223344);
      xact("t2_strb", 1'b1, 1'b1, 32'h12, 32'hFFFFFFA5);
      xact("t2_ld", 1'b0, 1'b0, 32'h10, 32'h0);
      chk("t2_model", ref_mem[4], 32'h11A53344);
      xact("t3_ldrb3", 1'b0, 1'b1, 32'h13, 32'h0);
      xact("t3_ldrb0", 1'b0, 1'b1, 32'h10, 32'h0);
      xact("t4_misal", 1'b0, 1'b0, 32'h06, 32'h0);
      xact("t4_mis_st", 1'b1, 1'b0, 32'h06, 32'hCAFEF00D);
      xact("t4_chk", 1'b0, 1'b0, 32'h04, 32'h0);
      b2b();
      abort_test();
      xact("alias_st", 1'b1, 1'b0, 32'(DEPTH * 4), 32'h0BADF00D);
      xact("alias_ld", 1'b0, 1'b0, 32'h0, 32'h0);

      for (int i = 0; i < 200; i++) begin
         we  = 1'($urandom);
         byt = 1'($urandom);
         a   = {$urandom_range(0, 255), 24'h0} |
               32'($urandom_range(0, 15) * 4) |
               32'($urandom_range(0, 3)) |
               ($urandom_range(0, 1) ? 32'(DEPTH * 4) : 32'h0);
         xact("rnd", we, byt, a, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500us;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
